// File: rtl/stage_id_sb.sv
// Decode-stage operand network with a per-register scoreboard.
// Holds one decoded instruction, resolves op1/op2 from prioritised bypass
// sources or the register file, stalls on long-latency results that are not
// yet on a bypass source, and hands the instruction to EX with valid/ready.
module stage_id_sb #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int N_FWD     = 3,
  parameter int LONG_LAT  = 1,
  parameter int REG0_ZERO = 1,
  localparam int RW       = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [RW-1:0]         in_rs1,
  input  logic [RW-1:0]         in_rs2,
  input  logic                  in_r_rs1,
  input  logic                  in_r_rs2,
  input  logic [RW-1:0]         in_rd,
  input  logic                  in_w_rd,
  input  logic                  in_long,
  input  logic                  in_op1_pc,
  input  logic                  in_op2_imm,
  input  logic [XLEN-1:0]       in_imm,
  output logic [RW-1:0]         rf_raddr1,
  output logic [RW-1:0]         rf_raddr2,
  input  logic [XLEN-1:0]       rf_rdata1,
  input  logic [XLEN-1:0]       rf_rdata2,
  input  logic [N_FWD-1:0]      fwd_valid,
  input  logic [N_FWD*RW-1:0]   fwd_rd,
  input  logic [N_FWD*XLEN-1:0] fwd_data,
  output logic                  out_valid,
  output logic [XLEN-1:0]       out_pc,
  output logic [XLEN-1:0]       out_op1,
  output logic [XLEN-1:0]       out_op2,
  output logic [RW-1:0]         out_rd,
  output logic                  out_w_rd,
  output logic                  out_long,
  output logic                  stall
);

  // Counter width; a zero latency still needs one (constant-zero) bit.
  localparam int CW = (LONG_LAT > 0) ? $clog2(LONG_LAT + 1) : 1;
  localparam logic [CW-1:0] LAT = CW'(LONG_LAT);
  localparam logic [CW-1:0] ONE = CW'(32'd1);
  localparam logic          R0Z = (REG0_ZERO != 32'sd0);

  // Held instruction fields
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [RW-1:0]   rs1_q, rs1_d;
  logic [RW-1:0]   rs2_q, rs2_d;
  logic            r_rs1_q, r_rs1_d;
  logic            r_rs2_q, r_rs2_d;
  logic [RW-1:0]   rd_q, rd_d;
  logic            w_rd_q, w_rd_d;
  logic            long_q, long_d;
  logic            op1_pc_q, op1_pc_d;
  logic            op2_imm_q, op2_imm_d;
  logic [XLEN-1:0] imm_q, imm_d;

  // Scoreboard: remaining cycles until a long result reaches a bypass source
  logic [CW-1:0]   cnt_q [NREG];
  logic [CW-1:0]   cnt_d [NREG];

  logic            busy1;
  logic            busy2;
  logic            stall_c;
  logic            issue;
  logic            sb_write;
  logic [XLEN-1:0] op1_c;
  logic [XLEN-1:0] op2_c;

  // Bypass lookup: the lowest-numbered (youngest) matching source wins, so
  // the loop walks from oldest to youngest and lets later hits overwrite.
  function automatic logic [XLEN-1:0] fwd_pick(
    input logic [RW-1:0]         rs,
    input logic [XLEN-1:0]       rf_val,
    input logic [N_FWD-1:0]      f_valid,
    input logic [N_FWD*RW-1:0]   f_rd,
    input logic [N_FWD*XLEN-1:0] f_data
  );
    logic [XLEN-1:0] res;
    res = rf_val;
    for (int i = N_FWD - 1; i >= 0; i--) begin
      if (f_valid[i] && (f_rd[i*RW +: RW] == rs)) begin
        res = f_data[i*XLEN +: XLEN];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Hazard detection and issue qualification
  always_comb begin
    busy1    = (cnt_q[rs1_q] != '0);
    busy2    = (cnt_q[rs2_q] != '0);
    stall_c  = valid_q && !flush &&
               ((r_rs1_q && !op1_pc_q && busy1) ||
                (r_rs2_q && !op2_imm_q && busy2));
    issue    = valid_q && !stall_c && !flush;
    sb_write = issue && w_rd_q && ((rd_q != '0) || !R0Z);
  end

  // Operand resolution: pc/imm select, then hardwired zero, then bypass, then RF
  always_comb begin
    op1_c = '0;
    op2_c = '0;
    if (op1_pc_q) begin
      op1_c = pc_q;
    end else if (R0Z && (rs1_q == '0)) begin
      op1_c = '0;
    end else begin
      op1_c = fwd_pick(rs1_q, rf_rdata1, fwd_valid, fwd_rd, fwd_data);
    end
    if (op2_imm_q) begin
      op2_c = imm_q;
    end else if (R0Z && (rs2_q == '0)) begin
      op2_c = '0;
    end else begin
      op2_c = fwd_pick(rs2_q, rf_rdata2, fwd_valid, fwd_rd, fwd_data);
    end
  end

  // Pipeline register next state: capture when not stalled or when flushing
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    r_rs1_d   = r_rs1_q;
    r_rs2_d   = r_rs2_q;
    rd_d      = rd_q;
    w_rd_d    = w_rd_q;
    long_d    = long_q;
    op1_pc_d  = op1_pc_q;
    op2_imm_d = op2_imm_q;
    imm_d     = imm_q;
    if (flush || !stall_c) begin
      valid_d   = in_valid && !flush;
      pc_d      = in_pc;
      rs1_d     = in_rs1;
      rs2_d     = in_rs2;
      r_rs1_d   = in_r_rs1;
      r_rs2_d   = in_r_rs2;
      rd_d      = in_rd;
      w_rd_d    = in_w_rd;
      long_d    = in_long;
      op1_pc_d  = in_op1_pc;
      op2_imm_d = in_op2_imm;
      imm_d     = in_imm;
    end else begin
      valid_d   = valid_q;
    end
  end

  // Scoreboard next state: issuing rd is loaded, every other busy count ticks down
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (sb_write && (rd_q == RW'(r))) begin
        cnt_d[r] = long_q ? LAT : '0;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - ONE;
      end else begin
        cnt_d[r] = cnt_q[r];
      end
    end
  end

  // Held instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      r_rs1_q   <= 1'b0;
      r_rs2_q   <= 1'b0;
      rd_q      <= '0;
      w_rd_q    <= 1'b0;
      long_q    <= 1'b0;
      op1_pc_q  <= 1'b0;
      op2_imm_q <= 1'b0;
      imm_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      r_rs1_q   <= r_rs1_d;
      r_rs2_q   <= r_rs2_d;
      rd_q      <= rd_d;
      w_rd_q    <= w_rd_d;
      long_q    <= long_d;
      op1_pc_q  <= op1_pc_d;
      op2_imm_q <= op2_imm_d;
      imm_q     <= imm_d;
    end
  end

  // Scoreboard counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  assign stall     = stall_c;
  assign in_ready  = !stall_c;
  assign out_valid = issue;
  assign out_pc    = pc_q;
  assign out_op1   = op1_c;
  assign out_op2   = op2_c;
  assign out_rd    = rd_q;
  assign out_w_rd  = w_rd_q;
  assign out_long  = long_q;
  assign rf_raddr1 = rs1_q;
  assign rf_raddr2 = rs2_q;

endmodule
